// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial subtractor controller, one full-subtractor slice per clock, LSB first
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] diff_sh;
   logic             brw;
   logic             a_msb;
   logic             b_msb;
   logic [CW-1:0]    cnt;

   logic             d_bit;
   logic             brw_nxt;
   logic             last_bit;
   logic [WIDTH-1:0] diff_fin;

   // Single shared full-subtractor slice.
   assign d_bit    = a_sh[0] ^ b_sh[0] ^ brw;
   assign brw_nxt  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
   assign last_bit = (cnt == CW'(WIDTH - 1));
   assign diff_fin = {d_bit, diff_sh[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         diff_sh <= '0;
         brw     <= 1'b0;
         a_msb   <= 1'b0;
         b_msb   <= 1'b0;
         cnt     <= '0;
         diff    <= '0;
         bout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh    <= a;
                  b_sh    <= b;
                  diff_sh <= '0;
                  brw     <= bin;
                  a_msb   <= a[WIDTH-1];
                  b_msb   <= b[WIDTH-1];
                  cnt     <= '0;
               end
            end
            RUN: begin
               a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
               diff_sh <= diff_fin;
               brw     <= brw_nxt;
               cnt     <= cnt + CW'(1);
               // The bit shifted in on the last slice is the result MSB.
               if (last_bit) begin
                  diff <= diff_fin;
                  bout <= brw_nxt;
                  ovf  <= (a_msb != b_msb) && (d_bit != a_msb);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
